// File: rtl/regfile_mp.sv
// Multi-port general register file: one write port and NUM_RD read ports.
// Register 0 can be hardwired to zero, and a write can be forwarded to reads in the same cycle.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 3,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  parameter int REG_RD  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (NUM_RD < 1 || ADDR_W < 1) begin : g_param_check
      $error("regfile_mp: NUM_RD and ADDR_W must both be at least 1");
    end
  endgenerate

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wr_en;

  // Writes to register 0 are dropped when it is hardwired, so its flop never leaves zero.
  assign wr_en = we && !((ZERO_R0 != 0) && (wa == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wa] <= wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra_i;
      logic [DATA_W-1:0] raw;

      assign ra_i = ra[gi*ADDR_W +: ADDR_W];

      // The zero-register rule is applied last, so it overrides the bypass path.
      always_comb begin
        raw = mem_reg[ra_i];
        if ((BYPASS != 0) && we && (wa == ra_i)) begin
          raw = wd;
        end
        if ((ZERO_R0 != 0) && (ra_i == '0)) begin
          raw = '0;
        end
      end

      if (REG_RD != 0) begin : g_reg_out
        logic [DATA_W-1:0] rd_reg;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            rd_reg <= '0;
          end else begin
            rd_reg <= raw;
          end
        end

        assign rd[gi*DATA_W +: DATA_W] = rd_reg;
      end else begin : g_comb_out
        assign rd[gi*DATA_W +: DATA_W] = raw;
      end
    end
  endgenerate

endmodule
